// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the common-memory arbiter.
//   req_id_t        : requester identifiers (V=0, C=1, D=2)
//   tag_t           : read-return tag {valid, id} carried alongside the RAM latency
//   ram_lat_ok()    : legal range check for the RAM read latency parameter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ID_V = 2'd0,
      ID_C = 2'd1,
      ID_D = 2'd2
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   localparam int unsigned RAM_LAT_MIN = 1;
   localparam int unsigned RAM_LAT_MAX = 4;

   function automatic bit ram_lat_ok(input int unsigned lat);
      return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
   endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: RAM_LAT-deep shift register of read tags. A tag entering with
// the registered RAM address leaves in the cycle mem_q carries its data.
//   clock, reset : memory clock, asynchronous active-high reset (clears all tags)
//   tag_i        : tag of the access granted this cycle
//   tag_o        : tag aligned with the current mem_q
module arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned RAM_LAT = 1
) (
   input  logic clock,
   input  logic reset,
   input  tag_t tag_i,
   output tag_t tag_o
);

   if (!ram_lat_ok(RAM_LAT)) begin : g_lat_chk
      $error("arb_tag_pipe: RAM_LAT out of range 1..4");
   end

   tag_t pipe_q [RAM_LAT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_i;
         for (int unsigned i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o = pipe_q[RAM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between video fetch (V),
// CPU (C) and DMA/blitter (D). One grant per cycle; RAM address, data and write
// strobe are registered; read data is routed back by a tag pipeline.
//   v_*   : video read port (req/addr in, ack/rdata/valid out)
//   c_*   : CPU port (req/addr/wdata/we in, ack/rdata/valid out)
//   d_*   : DMA port, same shape as the CPU port
//   mem_* : RAM interface (a/d/we registered, q is read data)
// Build option ARB_RR_EN: C and D share the lower level round-robin instead of
// fixed C > D with the D starvation override.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 8,
   parameter int unsigned RAM_LAT = 1,
   parameter int unsigned STARVE  = 15
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          v_req,
   input  logic [AW-1:0] v_addr,
   output logic          v_ack,
   output logic [DW-1:0] v_rdata,
   output logic          v_valid,
   input  logic          c_req,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   input  logic          c_we,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   output logic          c_valid,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_we,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   output logic          mem_we,
   input  logic [DW-1:0] mem_q
);

   // A held request is masked in its ack cycle so it cannot be granted twice.
   logic v_el, c_el, d_el;
   assign v_el = v_req & ~v_ack;
   assign c_el = c_req & ~c_ack;
   assign d_el = d_req & ~d_ack;

   logic gnt_v, gnt_c, gnt_d;

`ifdef ARB_RR_EN
   logic rr_d_q;  // 1: D has the lower-level turn

   always_comb begin
      gnt_v = v_el;
      gnt_c = 1'b0;
      gnt_d = 1'b0;
      if (!v_el) begin
         if (c_el && d_el) begin
            gnt_c = ~rr_d_q;
            gnt_d = rr_d_q;
         end else begin
            gnt_c = c_el;
            gnt_d = d_el;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)      rr_d_q <= 1'b0;
      else if (gnt_c) rr_d_q <= 1'b1;
      else if (gnt_d) rr_d_q <= 1'b0;
   end
`else
   localparam logic [7:0] STARVE_L = 8'(STARVE);

   logic [7:0] starve_q, starve_d;
   logic       d_force;

   // A starved D outranks C but never V.
   assign d_force = d_el && (starve_q == STARVE_L);

   always_comb begin
      gnt_v = v_el;
      gnt_d = !v_el && d_el && (d_force || !c_el);
      gnt_c = !v_el && c_el && !d_force;
   end

   always_comb begin
      starve_d = starve_q;
      if (d_ack || !d_req)
         starve_d = '0;
      else if (d_el && !gnt_d && (starve_q != STARVE_L))
         starve_d = starve_q + 8'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`endif

   tag_t tag_in, tag_out;

   always_comb begin
      tag_in.valid = gnt_v | (gnt_c & ~c_we) | (gnt_d & ~d_we);
      tag_in.id    = gnt_v ? ID_V : (gnt_c ? ID_C : ID_D);
   end

   arb_tag_pipe #(.RAM_LAT(RAM_LAT)) u_tag_pipe (
      .clock (clock),
      .reset (reset),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v_ack   <= 1'b0;
         c_ack   <= 1'b0;
         d_ack   <= 1'b0;
         mem_a   <= '0;
         mem_d   <= '0;
         mem_we  <= 1'b0;
         v_rdata <= '0;
         c_rdata <= '0;
         d_rdata <= '0;
         v_valid <= 1'b0;
         c_valid <= 1'b0;
         d_valid <= 1'b0;
      end else begin
         v_ack  <= gnt_v;
         c_ack  <= gnt_c;
         d_ack  <= gnt_d;
         mem_we <= 1'b0;
         if (gnt_v) begin
            mem_a <= v_addr;
            mem_d <= '0;
         end else if (gnt_c) begin
            mem_a  <= c_addr;
            mem_d  <= c_wdata;
            mem_we <= c_we;
         end else if (gnt_d) begin
            mem_a  <= d_addr;
            mem_d  <= d_wdata;
            mem_we <= d_we;
         end

         v_valid <= 1'b0;
         c_valid <= 1'b0;
         d_valid <= 1'b0;
         if (tag_out.valid) begin
            case (tag_out.id)
               ID_V: begin v_rdata <= mem_q; v_valid <= 1'b1; end
               ID_C: begin c_rdata <= mem_q; c_valid <= 1'b1; end
               ID_D: begin d_rdata <= mem_q; d_valid <= 1'b1; end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter with a
// scoreboard. The monitor predicts each cycle's grant from the priority rules,
// checks acks and RAM-side fields, keeps a reference memory image, and queues
// expected read returns per requester. RAM model here needs RAM_LAT >= 2.
module tb_mem_arbiter;

   localparam int unsigned AW      = 16;
   localparam int unsigned DW      = 8;
   localparam int unsigned RAM_LAT = 3;
   localparam int unsigned STARVE  = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          v_req = 1'b0, c_req = 1'b0, d_req = 1'b0;
   logic [AW-1:0] v_addr = '0, c_addr = '0, d_addr = '0;
   logic [DW-1:0] c_wdata = '0, d_wdata = '0;
   logic          c_we = 1'b0, d_we = 1'b0;
   logic          v_ack, c_ack, d_ack, v_valid, c_valid, d_valid;
   logic [DW-1:0] v_rdata, c_rdata, d_rdata;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_d, mem_q;
   logic          mem_we;

   mem_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(RAM_LAT), .STARVE(STARVE)) dut (
      .clock(clock), .reset(reset),
      .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata), .v_valid(v_valid),
      .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
      .c_ack(c_ack), .c_rdata(c_rdata), .c_valid(c_valid),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
   );

   always #5 clock = ~clock;

   // RAM: combinational read of the registered address, then RAM_LAT-1 delay stages.
   logic [DW-1:0] ram    [2**AW];
   logic [DW-1:0] rd_dly [RAM_LAT-1];
   always @(posedge clock) begin
      if (mem_we) ram[mem_a] <= mem_d;
      rd_dly[0] <= ram[mem_a];
      for (int i = 1; i < int'(RAM_LAT) - 1; i++) rd_dly[i] <= rd_dly[i-1];
   end
   assign mem_q = rd_dly[RAM_LAT-2];

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int unsigned n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct { int unsigned due; logic [DW-1:0] data; } rd_exp_t;
   rd_exp_t q_v[$], q_c[$], q_d[$];
   logic [DW-1:0] ref_mem [2**AW];

   logic [2:0]    exp_ack;
   logic          pend_v;
   int            pend_id;
   logic [AW-1:0] pend_addr, last_a;
   logic [DW-1:0] pend_wd;
   logic          pend_we;
   int unsigned   sc;
   logic          rr_d;

   task automatic chk_port(input int p, input logic vld, input logic [DW-1:0] rd);
      rd_exp_t e;
      bit have;
      string pn;
      have = 0;
      pn = (p == 0) ? "V" : (p == 1) ? "C" : "D";
      case (p)
         0: if (q_v.size() > 0) begin e = q_v[0]; have = 1; end
         1: if (q_c.size() > 0) begin e = q_c[0]; have = 1; end
         default: if (q_d.size() > 0) begin e = q_d[0]; have = 1; end
      endcase
      if (vld && !have) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_valid: got unexpected pulse, expected none (cycle %0d)", pn, cyc);
      end else if (have && (vld || e.due <= cyc)) begin
         case (p)
            0: void'(q_v.pop_front());
            1: void'(q_c.pop_front());
            default: void'(q_d.pop_front());
         endcase
         chk({pn, "_valid_cycle"}, 64'(vld ? cyc : 0), 64'(e.due));
         if (vld) chk({pn, "_rdata"}, 64'(rd), 64'(e.data));
      end
   endtask

   always @(negedge clock) begin
      logic [2:0] el;
      int w;
      if (reset) begin
         chk("reset_outputs", 64'({v_ack, c_ack, d_ack, v_valid, c_valid, d_valid, mem_we,
                                   v_rdata, c_rdata, d_rdata, mem_a, mem_d}), 64'd0);
         q_v.delete(); q_c.delete(); q_d.delete();
         exp_ack = '0; pend_v = 0; pend_id = 0; pend_addr = '0; pend_wd = '0; pend_we = 0;
         last_a = '0; sc = 0; rr_d = 0;
      end else begin
         exp_ack = '0;
         if (pend_v) exp_ack[pend_id] = 1'b1;
         chk("acks{d,c,v}", 64'({d_ack, c_ack, v_ack}), 64'(exp_ack));
         if (pend_v) begin
            chk("mem_a", 64'(mem_a), 64'(pend_addr));
            chk("mem_we", 64'(mem_we), 64'(pend_we));
            chk("mem_d", 64'(mem_d), 64'(pend_wd));
            last_a = pend_addr;
            if (pend_we) ref_mem[pend_addr] = pend_wd;
            else begin
               rd_exp_t e;
               e.due = cyc + RAM_LAT;
               e.data = ref_mem[pend_addr];
               case (pend_id)
                  0: q_v.push_back(e);
                  1: q_c.push_back(e);
                  default: q_d.push_back(e);
               endcase
            end
         end else begin
            chk("mem_we_idle", 64'(mem_we), 64'd0);
            chk("mem_a_hold", 64'(mem_a), 64'(last_a));
         end
         chk_port(0, v_valid, v_rdata);
         chk_port(1, c_valid, c_rdata);
         chk_port(2, d_valid, d_rdata);

         // Grant for this cycle, from the priority rules.
         el = {d_req, c_req, v_req} & ~exp_ack;
         w = -1;
`ifdef ARB_RR_EN
         if (el[0]) w = 0;
         else if (el[1] && el[2]) w = rr_d ? 2 : 1;
         else if (el[1]) w = 1;
         else if (el[2]) w = 2;
         if (w == 1) rr_d = 1;
         if (w == 2) rr_d = 0;
`else
         if (el[0]) w = 0;
         else if (el[2] && sc == STARVE) w = 2;
         else if (el[1]) w = 1;
         else if (el[2]) w = 2;
         if (exp_ack[2] || !d_req) sc = 0;
         else if (el[2] && w != 2 && sc < STARVE) sc++;
`endif
         pend_v = (w >= 0);
         pend_id = (w >= 0) ? w : 0;
         case (w)
            0: begin pend_addr = v_addr; pend_we = 0; pend_wd = '0; end
            1: begin pend_addr = c_addr; pend_we = c_we; pend_wd = c_wdata; end
            2: begin pend_addr = d_addr; pend_we = d_we; pend_wd = d_wdata; end
            default: ;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic bit pct(input int n);
      return $urandom_range(99) < n;
   endfunction

   function automatic logic get_req(input int p);
      return (p == 0) ? v_req : (p == 1) ? c_req : d_req;
   endfunction

   function automatic logic get_ack(input int p);
      return (p == 0) ? v_ack : (p == 1) ? c_ack : d_ack;
   endfunction

   task automatic drop_req(input int p);
      case (p)
         0: v_req = 0;
         1: c_req = 0;
         default: d_req = 0;
      endcase
   endtask

   task automatic new_req(input int p);
      logic [AW-1:0] a;
      a = pct(15) ? AW'($urandom) : AW'($urandom_range(15));
      case (p)
         0: begin v_req = 1; v_addr = a; end
         1: begin c_req = 1; c_addr = a; c_we = pct(50); c_wdata = DW'($urandom); end
         default: begin d_req = 1; d_addr = a; d_we = pct(50); d_wdata = DW'($urandom); end
      endcase
   endtask

   task automatic rand_phase(input int n, input logic [2:0] en, input int rate,
                             input int keep, input int wdraw);
      for (int i = 0; i < n; i++) begin
         for (int p = 0; p < 3; p++) begin
            if (!en[p]) drop_req(p);
            else if (get_req(p) && get_ack(p)) begin
               if (pct(keep)) new_req(p); else drop_req(p);
            end else if (get_req(p)) begin
               if (pct(wdraw)) drop_req(p);
               else if (pct(10)) new_req(p);
            end else if (pct(rate)) new_req(p);
         end
         tick();
      end
   endtask

   task automatic wait_ack(input int p);
      for (int i = 0; i < 16; i++) begin
         tick();
         if (get_ack(p)) break;
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         ram[i] = DW'(i * 37 + 5);
         ref_mem[i] = DW'(i * 37 + 5);
      end
      repeat (3) tick();
      reset = 0;
      tick();

      // CPU read in flight when reset hits: its return must vanish.
      c_req = 1; c_addr = 16'h1234; c_we = 0;
      wait_ack(1);
      c_req = 0;
      tick();
      reset = 1;
      repeat (3) tick();
      reset = 0;
      repeat (6) tick();

      // Lone CPU write then read-back.
      c_req = 1; c_addr = 16'h00FF; c_we = 1; c_wdata = 8'hA5;
      wait_ack(1);
      c_req = 0;
      tick();
      c_req = 1; c_we = 0;
      wait_ack(1);
      c_req = 0;
      repeat (6) tick();

      // Video reads 1..3 back-to-back with CPU writes interleaved.
      v_req = 1; v_addr = 16'h0001;
      c_req = 1; c_we = 1; c_addr = 16'h0002; c_wdata = 8'h11;
      for (int i = 0; i < 20 && (v_req || c_req); i++) begin
         tick();
         if (v_ack) begin if (v_addr == 16'h0003) v_req = 0; else v_addr = v_addr + 1; end
         if (c_ack) begin
            if (c_addr == 16'h0004) c_req = 0;
            else begin c_addr = c_addr + 1; c_wdata = c_wdata + 8'h11; end
         end
      end
      repeat (8) tick();

      rand_phase(150, 3'b011, 100, 100, 0);   // V and C continuous
      rand_phase(150, 3'b110, 100, 100, 0);   // C and D continuous
      rand_phase(200, 3'b111, 100, 100, 0);   // all three continuous: starvation path
      rand_phase(1500, 3'b111, 40, 60, 5);    // mixed traffic with withdrawals
      rand_phase(30, 3'b000, 0, 0, 0);        // drain

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port synchronous RAM, the 64K common memory, between three requesters: video fetch (V), CPU data port (C) and a DMA/blitter port (D).
- Arbitrates one access per cycle and registers the RAM address, data and write strobe.
- Routes read data back to the requester that issued the read, using a tag pipeline matched to RAM latency.
- Sits between the core/adapter and the RAM instance in the board top level, in the memory clock domain.

Parameters:
AW, 16, address width
DW, 8, data width
RAM_LAT, 1, RAM read latency in cycles from registered address to mem_q valid (1..4)
STARVE, 15, consecutive cycles D may be denied while requesting before it is forced to top priority (1..255)

Ports:
clock  in  1  memory clock
reset  in  1  asynchronous, active-high reset
v_req  in  1  video read request, held until v_ack
v_addr  in  AW  video address
v_ack  out  1  one-cycle pulse: V request issued to RAM
v_rdata  out  DW  video read data
v_valid  out  1  one-cycle pulse: v_rdata valid
c_req  in  1  CPU request, held until c_ack
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_we  in  1  CPU write (1) / read (0)
c_ack  out  1  CPU request issued
c_rdata  out  DW  CPU read data
c_valid  out  1  CPU read data valid
d_req, d_addr, d_wdata, d_we  in  1/AW/DW/1  DMA request, same rules as CPU
d_ack, d_rdata, d_valid  out  1/DW/1  DMA responses
mem_a  out  AW  RAM address (registered)
mem_d  out  DW  RAM write data (registered)
mem_we  out  1  RAM write enable (registered)
mem_q  in  DW  RAM read data

Behaviour:
- Reset: all outputs 0, tag pipeline cleared, starvation counter 0, round-robin pointer on C. Reads in flight at reset are dropped and produce no valid pulse.
- Eligibility: a requester is eligible in cycle k if its req=1 and its ack=0 in cycle k. The ack-cycle mask prevents a double grant on a held req.
- Priority, fixed: V > C > D. Exception: when starve_cnt==STARVE and d_req is eligible, D wins over C but never over V.
- Grant issued in cycle k: at the edge ending cycle k, mem_a/mem_d/mem_we load the winner's fields (V: we=0, d=0) and the winner's ack asserts for cycle k+1. With no winner, mem_we=0 and mem_a holds its value.
- A write is complete at ack. A read is tagged {valid, id[1:0]} in a RAM_LAT-deep shift register. The matching x_rdata<=mem_q and x_valid pulse appear in cycle k+1+RAM_LAT. With RAM_LAT=1 a read granted in cycle k returns data in cycle k+2. x_rdata holds until the next valid for that port.
- Throughput: max one grant per cycle overall. A single requester holding req continuously gets one grant every 2 cycles.
- Starvation counter (8-bit): increments each cycle D is eligible and not granted, saturating at STARVE. Clears on d_ack or when d_req=0.
- Simultaneous events: when all three are eligible, V wins. In the next cycle C wins (V masked by v_ack), then V, then C, and so on. D advances only via the starvation rule or when C is idle.
- Requester changes addr/we while req=1 and before ack: allowed; the value sampled in the grant cycle is used.
- Deassert req before ack: the request is withdrawn and no ack is produced.

Optional Feature:
ARB_RR_EN.
- Defined: C and D share the lower priority level round-robin. A 1-bit pointer flips to the other requester after each C or D grant. V stays highest. The starvation counter and STARVE are not built.
- Undefined: fixed C > D plus the starvation rule as described above.

Decomposition:
- Shared package `mem_arb_pkg`: requester id constants ID_V=0, ID_C=1, ID_D=2; tag struct {valid, id}; RAM_LAT bounds check.
- One sub-module, `arb_tag_pipe`: parameterised RAM_LAT-deep tag shift register that outputs the delayed tag for return routing.
- Grant logic and counters stay in the top module.

Test Plan:
1. Reset mid-read: C read at 0x1234 granted, reset asserted before return -> no c_valid, all outputs 0 during reset.
2. Lone CPU write then read: write 0xA5 to 0x00FF -> c_ack one cycle after request, mem_we=1 with mem_a=0x00FF. Read of 0x00FF -> c_valid two cycles after grant with c_rdata=0xA5.
3. V and C requesting continuously -> grants alternate V,C,V,C. Each v_valid carries data from its own address; no cross-routing.
4. C continuous, D requesting, STARVE=3 (fixed-priority build) -> d_ack within 5 cycles of d_req; counter returns to 0 after d_ack.
5. ARB_RR_EN build, C and D continuous, V idle -> grants C,D,C,D; each requester acked every second cycle.
6. RAM_LAT=3, V reads 0x0001, 0x0002, 0x0003 back-to-back with C writes interleaved -> v_valid at grant+4 each, data in address order.
